dpram_loader: RTL and testbench
===============================

// Module: dpram_loader
// PURPOSE
//  Writer-side client for the generic dual-port RAM. Takes a byte stream (ROM/NVRAM download),
//  packs bytes into data_width words and writes them to one dpram port from base_address.
//  It then reads the region back and compares 8-bit checksums.
//  Sits between the download/ioctl path and the dpram write port. RAM reads have 1-cycle latency.
// PARAMETERS
//  address_width  10  RAM address bits; region wraps modulo 2**address_width
//  data_width     8   RAM word width; must be a multiple of 8; BYTES = data_width/8
//  base_address   0   first word address written and read
// PORTS
//  clock      in   1              single clock, rising edge
//  reset      in   1              asynchronous, active-high
//  start      in   1              1-cycle pulse; latches length and begins a load; ignored while busy
//  length     in   address_width+1  words to load; values > 2**address_width clamp to 2**address_width
//  s_valid    in   1              stream byte valid
//  s_data     in   8              stream byte
//  s_ready    out  1              byte accepted when s_valid && s_ready
//  wren       out  1              RAM write enable (registered, 1-cycle pulse per word)
//  address    out  address_width  RAM address (registered)
//  data       out  data_width     RAM write data (registered)
//  q          in   data_width     RAM read data, valid 1 cycle after address presented
//  busy       out  1              high from the cycle after start until DONE
//  done       out  1              high in DONE; cleared by next accepted start
//  match      out  1              valid while done: readback sum == written sum
//  checksum   out  8              sum of all bytes accepted, modulo 256
// BEHAVIOUR
//  - Reset (async): IDLE; s_ready=0, wren=0, address=0, data=0, busy=0, done=0, match=0, checksum=0.
//    Asserting reset mid-operation aborts at once. No partial word is written.
//  - FSM: IDLE -> LOAD -> VERIFY -> CHECK -> DONE; DONE -> LOAD on start.
//  - start in IDLE/DONE: next cycle busy=1, done=0, match=0, checksum=0, word/byte counters=0.
//    State becomes LOAD, or DONE with match=1 if the clamped length==0 (no wren issued).
//  - LOAD: s_ready=1. Each accepted byte goes into lane byte_idx (bits 8*i+7:8*i, lowest first).
//    Each accepted byte is also added to checksum.
//    On the byte completing a word (byte_idx==BYTES-1), the next cycle gives wren=1,
//    address=base_address+word_idx (mod 2**address_width) and data=packed word.
//    s_ready stays 1, so back-to-back bytes are accepted with no bubble.
//  - After the final byte of word length-1 is accepted: s_ready=0 from the next cycle.
//    The final wren pulse still issues. The state then goes to VERIFY.
//    Extra stream bytes are never accepted.
//  - VERIFY: wren=0. Issue addresses base_address+k for k=0..length-1, one per cycle.
//    Each q is sampled the cycle after its address, and all BYTES lanes are added to rd_sum (mod 256).
//  - CHECK: one cycle to absorb the last q. Then DONE: done=1, busy=0,
//    match=(rd_sum==checksum); outputs held until the next start.
//  - Wrap: base_address+index overflow wraps to 0; a full-size region (2**address_width) is legal.
//  - s_valid while not in LOAD: ignored (s_ready=0). A start pulse during LOAD/VERIFY/CHECK is ignored.
// STRUCTURE
//  - Shared package dpram_pkg: state encoding localparams (ST_IDLE, ST_LOAD, ST_VERIFY, ST_CHECK, ST_DONE)
//    and function byte_sum(word) returning the 8-bit sum of the word's lanes.
//  - One sub-module is natural: byte_packer (byte_idx counter, lane shift register, word_ready pulse).
//    The FSM, address generator and checksums stay in dpram_loader.
// TESTING (bench instantiates dpram_loader driving port A of a dpram model with 1-cycle read latency)
//  1. aw=4, dw=8, base=0, length=3, bytes 11,22,33 back-to-back
//     -> wren at addr 0,1,2 data 11,22,33; done=1, match=1, checksum=0x66.
//  2. dw=16, length=2, bytes 01,02,03,04 -> writes 0x0201 @base, 0x0403 @base+1;
//     exactly 2 wren pulses; match=1.
//  3. aw=4, base=14, length=4, bytes A0..A3 with random s_valid gaps
//     -> addresses 14,15,0,1 in order; match=1.
//  4. As test 1, but port B overwrites addr 1 with 0x00 during VERIFY
//     -> done=1, match=0, checksum=0x66.
//  5. start with length=0 -> done=1 two cycles after start; match=1; no wren; s_ready stays 0.
//  6. reset pulsed after 2 bytes of a 3-word load -> wren/busy/s_ready 0 immediately;
//     restart with length=1, byte 5A -> write 5A @base, match=1.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared definitions for the dpram loader: controller state encoding and
// a helper that folds the byte lanes of a RAM word into an 8-bit sum.
package dpram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Widest RAM word byte_sum can fold; callers zero-extend narrower words.
  localparam int MAX_DATA_WIDTH = 256;

  // Sum of the lowest n_bytes byte lanes of word, modulo 256.
  function automatic logic [7:0] byte_sum(input logic [MAX_DATA_WIDTH-1:0] word,
                                          input int n_bytes);
    logic [7:0] sum;
    sum = '0;
    for (int i = 0; i < MAX_DATA_WIDTH / 8; i++) begin
      if (i < n_bytes) sum = sum + word[8*i +: 8];
    end
    return sum;
  endfunction

endpackage

// File: rtl/dpram_loader_byte_packer.sv
// byte_packer: collects accepted stream bytes into a data_width word,
// lowest lane first, and flags the byte that completes each word.
module byte_packer #(
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            s_data,
  output logic                  word_ready,
  output logic [data_width-1:0] word
);
  localparam int BYTES = data_width / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0]      byte_idx;
  logic [data_width-1:0] lanes;

  // Merge the incoming byte into its lane so the completed word is available
  // in the same cycle as its last byte.
  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves a variable unassigned would infer a latch.
  always_comb begin
    word = lanes;
    for (int i = 0; i < BYTES; i++) begin
      if (byte_idx == IDX_W'(i)) word[8*i +: 8] = s_data;
    end
    word_ready = accept && (byte_idx == IDX_W'(BYTES - 1));
  end

  // Lane register and byte counter; clear restarts packing at lane 0.
  // NOTE: the lane register is small, so it is reset along with the counter
  // to keep every flop in a known state after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (accept) begin
      lanes    <= word;
      byte_idx <= word_ready ? '0 : byte_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dpram_loader.sv
// dpram_loader: writes a packed byte stream into one dual-port RAM port from
// base_address, then reads the region back and compares 8-bit checksums.
module dpram_loader
  import dpram_pkg::*;
#(
  parameter int address_width = 10,
  parameter int data_width    = 8,
  parameter int base_address  = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [address_width:0]   length,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  output logic                     s_ready,
  output logic                     wren,
  output logic [address_width-1:0] address,
  output logic [data_width-1:0]    data,
  input  logic [data_width-1:0]    q,
  output logic                     busy,
  output logic                     done,
  output logic                     match,
  output logic [7:0]               checksum
);
  localparam int BYTES = data_width / 8;
  localparam logic [address_width:0]   FULL = {1'b1, {address_width{1'b0}}};
  localparam logic [address_width-1:0] BASE = address_width'(base_address);
  localparam logic [address_width:0]   ONE  = (address_width + 1)'(1);

  state_t                  state, state_next;
  logic [address_width:0]  len_q, word_idx, rd_idx;
  logic                    start_ok, accept, word_ready, addr_vld, q_vld;
  logic [data_width-1:0]   packed_word;
  logic [7:0]              rd_sum;

  assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
  // Ready only while words remain; drops the cycle after the last byte.
  assign s_ready  = (state == ST_LOAD) && (word_idx != len_q);
  assign accept   = s_valid && s_ready;
  assign busy     = (state == ST_LOAD) || (state == ST_VERIFY) || (state == ST_CHECK);
  assign done     = (state == ST_DONE);
  assign match    = done && (rd_sum == checksum);

  byte_packer #(.data_width(data_width)) u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_ok),
    .accept     (accept),
    .s_data     (s_data),
    .word_ready (word_ready),
    .word       (packed_word)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state. LOAD lingers one cycle past the last byte so the final
  // write pulse completes before readback starts.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_LOAD;
      ST_LOAD:          if (word_idx == len_q)
                          state_next = (len_q == '0) ? ST_DONE : ST_VERIFY;
      ST_VERIFY:        if (rd_idx == len_q) state_next = ST_CHECK;
      ST_CHECK:         state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
  end

  // Write/read address generation, write strobe and both checksums.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q    <= '0;
      word_idx <= '0;
      rd_idx   <= '0;
      wren     <= 1'b0;
      address  <= '0;
      data     <= '0;
      checksum <= '0;
      rd_sum   <= '0;
      addr_vld <= 1'b0;
      q_vld    <= 1'b0;
    end else begin
      wren     <= 1'b0;
      addr_vld <= 1'b0;
      q_vld    <= addr_vld;
      if (start_ok) begin
        len_q    <= (length > FULL) ? FULL : length;
        word_idx <= '0;
        rd_idx   <= '0;
        checksum <= '0;
        rd_sum   <= '0;
      end
      if (accept) checksum <= checksum + s_data;
      if (word_ready) begin
        wren     <= 1'b1;
        address  <= BASE + word_idx[address_width-1:0];
        data     <= packed_word;
        word_idx <= word_idx + ONE;
      end
      // Entering VERIFY: present the first readback address immediately.
      if (state == ST_LOAD && word_idx == len_q && len_q != '0) begin
        address  <= BASE;
        rd_idx   <= ONE;
        addr_vld <= 1'b1;
      end
      if (state == ST_VERIFY && rd_idx != len_q) begin
        address  <= BASE + rd_idx[address_width-1:0];
        rd_idx   <= rd_idx + ONE;
        addr_vld <= 1'b1;
      end
      // q belongs to the address presented in the previous cycle.
      if (q_vld) rd_sum <= rd_sum + byte_sum(MAX_DATA_WIDTH'(q), BYTES);
    end
  end

endmodule

// File: tb/tb_dpram_loader.sv
// Bench for dpram_loader: three configurations, each driving port A of a
// 1-cycle-latency RAM model; a reference model derives expected writes and sums.
`timescale 1ns/1ps
module tb_dpram_loader;
  localparam int AW     = 4;
  localparam int NWORDS = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [AW:0] length;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        start_a, start_b, start_c;

  // Instance a: dw=8, base=0. Instance b: dw=16, base=14. Instance c: dw=8, base=14.
  logic          s_ready_a, wren_a, busy_a, done_a, match_a;
  logic [AW-1:0] address_a;
  logic [7:0]    data_a, q_a, checksum_a;
  logic          s_ready_b, wren_b, busy_b, done_b, match_b;
  logic [AW-1:0] address_b;
  logic [15:0]   data_b, q_b;
  logic [7:0]    checksum_b;
  logic          s_ready_c, wren_c, busy_c, done_c, match_c;
  logic [AW-1:0] address_c;
  logic [7:0]    data_c, q_c, checksum_c;

  dpram_loader #(.address_width(AW), .data_width(8), .base_address(0)) u_dut_a (
    .clock(clock), .reset(reset), .start(start_a), .length(length),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a), .wren(wren_a),
    .address(address_a), .data(data_a), .q(q_a), .busy(busy_a), .done(done_a),
    .match(match_a), .checksum(checksum_a));

  dpram_loader #(.address_width(AW), .data_width(16), .base_address(14)) u_dut_b (
    .clock(clock), .reset(reset), .start(start_b), .length(length),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b), .wren(wren_b),
    .address(address_b), .data(data_b), .q(q_b), .busy(busy_b), .done(done_b),
    .match(match_b), .checksum(checksum_b));

  dpram_loader #(.address_width(AW), .data_width(8), .base_address(14)) u_dut_c (
    .clock(clock), .reset(reset), .start(start_c), .length(length),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_c), .wren(wren_c),
    .address(address_c), .data(data_c), .q(q_c), .busy(busy_c), .done(done_c),
    .match(match_c), .checksum(checksum_c));

  // RAM models; mem_a also has a port B used to corrupt a word during readback.
  logic [7:0]    mem_a [NWORDS];
  logic [15:0]   mem_b [NWORDS];
  logic [7:0]    mem_c [NWORDS];
  logic          pb_we = 1'b0;
  logic [AW-1:0] pb_addr = 4'd1;
  logic [7:0]    pb_data = 8'h00;

  always @(posedge clock) begin
    if (wren_a) mem_a[address_a] <= data_a;
    if (pb_we)  mem_a[pb_addr]   <= pb_data;
    q_a <= mem_a[address_a];
    if (wren_b) mem_b[address_b] <= data_b;
    q_b <= mem_b[address_b];
    if (wren_c) mem_c[address_c] <= data_c;
    q_c <= mem_c[address_c];
  end

  // Observed view of the instance under test.
  int         sel;
  logic       cur_ready, cur_busy, cur_done, cur_match;
  logic [7:0] cur_sum;
  always_comb begin
    cur_ready = s_ready_a; cur_busy = busy_a; cur_done = done_a;
    cur_match = match_a;   cur_sum  = checksum_a;
    case (sel)
      1: begin
        cur_ready = s_ready_b; cur_busy = busy_b; cur_done = done_b;
        cur_match = match_b;   cur_sum  = checksum_b;
      end
      2: begin
        cur_ready = s_ready_c; cur_busy = busy_c; cur_done = done_c;
        cur_match = match_c;   cur_sum  = checksum_c;
      end
      default: ;
    endcase
  end

  // Log of every write pulse from any instance.
  typedef struct { int inst; int addr; int data; } wr_t;
  wr_t wr_log[$];
  always @(negedge clock) begin
    if (wren_a) wr_log.push_back('{0, int'(address_a), int'(data_a)});
    if (wren_b) wr_log.push_back('{1, int'(address_b), int'(data_b)});
    if (wren_c) wr_log.push_back('{2, int'(address_c), int'(data_c)});
  end

  // Port B corruption: fires in the first readback cycle of instance a
  // (busy, not ready, no write pulse), ahead of the read of address 1.
  bit tamper_req  = 1'b0;
  bit tamper_done = 1'b0;
  always @(negedge clock) begin
    pb_we = 1'b0;
    if (!tamper_req) tamper_done = 1'b0;
    else if (!tamper_done && busy_a && !s_ready_a && !wren_a) begin
      pb_we       = 1'b1;
      tamper_done = 1'b1;
    end
  end

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] stim[$];

  task automatic set_start(input int inst, input logic v);
    start_a = (inst == 0) ? v : 1'b0;
    start_b = (inst == 1) ? v : 1'b0;
    start_c = (inst == 2) ? v : 1'b0;
  endtask

  // Runs one load on an instance and compares everything against the model.
  task automatic run_load(input int inst, input int len_in, input bit gaps,
                          input bit tamper, input bit mid_start, input string name);
    int nb_per, base, words, nbytes, idx, extra, cyc, exp_data, exp_addr;
    logic [7:0] exp_sum, exp_rd;
    bit exp_match;
    nb_per = (inst == 1) ? 2 : 1;
    base   = (inst == 0) ? 0 : 14;
    words  = (len_in > NWORDS) ? NWORDS : len_in;
    nbytes = words * nb_per;
    while (stim.size() < nbytes) stim.push_back(8'($urandom));
    exp_sum = 8'h00;
    for (int i = 0; i < nbytes; i++) exp_sum = exp_sum + stim[i];
    exp_rd = exp_sum;
    if (tamper) for (int i = 0; i < nb_per; i++) exp_rd = exp_rd - stim[nb_per + i];
    exp_match = (exp_rd == exp_sum);

    wr_log.delete();
    sel        = inst;
    tamper_req = tamper;
    @(negedge clock);
    length = (AW + 1)'(len_in);
    set_start(inst, 1'b1);
    @(negedge clock);
    set_start(inst, 1'b0);
    tests_run++;
    if (cur_busy !== 1'b1 || cur_done !== 1'b0 || cur_match !== 1'b0 || cur_sum !== 8'h00) begin
      tests_failed++;
      $display("FAIL %s start: busy/done/match/sum got %b%b%b/%h want 100/00",
               name, cur_busy, cur_done, cur_match, cur_sum);
    end

    idx = 0; extra = 0; cyc = 0;
    while (cur_done !== 1'b1 && cyc < 400) begin
      if (cyc > 0) @(negedge clock);
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data  = (idx < nbytes) ? stim[idx] : 8'hEE;
      set_start(inst, mid_start && cyc == 2);
      #1;
      if (s_valid && cur_ready) begin
        if (idx < nbytes) idx++;
        else extra++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    set_start(inst, 1'b0);
    tamper_req = 1'b0;

    tests_run++;
    if (cur_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s timeout: done got %b want 1", name, cur_done);
    end
    tests_run++;
    if (idx != nbytes || extra != 0) begin
      tests_failed++;
      $display("FAIL %s accepted: got %0d (+%0d extra) want %0d", name, idx, extra, nbytes);
    end
    tests_run++;
    if (wr_log.size() != words) begin
      tests_failed++;
      $display("FAIL %s write count: got %0d want %0d", name, wr_log.size(), words);
    end
    for (int k = 0; k < words && k < wr_log.size(); k++) begin
      exp_addr = (base + k) % NWORDS;
      exp_data = 0;
      for (int i = 0; i < nb_per; i++) exp_data = exp_data | (int'(stim[k*nb_per + i]) << (8*i));
      tests_run++;
      if (wr_log[k].inst != inst || wr_log[k].addr != exp_addr || wr_log[k].data != exp_data) begin
        tests_failed++;
        $display("FAIL %s write %0d: got inst %0d addr %0d data %h want inst %0d addr %0d data %h",
                 name, k, wr_log[k].inst, wr_log[k].addr, wr_log[k].data, inst, exp_addr, exp_data);
      end
    end
    tests_run++;
    if (cur_sum !== exp_sum || cur_match !== exp_match || cur_busy !== 1'b0 || cur_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s result: sum %h match %b busy %b ready %b want sum %h match %b busy 0 ready 0",
               name, cur_sum, cur_match, cur_busy, cur_ready, exp_sum, exp_match);
    end
    stim.delete();
  endtask

  task automatic test_reset();
    tests_run++;
    if ({wren_a, busy_a, done_a, match_a, s_ready_a} !== 5'b0 || address_a !== '0 ||
        data_a !== '0 || checksum_a !== '0 || {wren_b, busy_b, done_b, s_ready_b} !== 4'b0 ||
        data_b !== '0 || checksum_b !== '0) begin
      tests_failed++;
      $display("FAIL reset: a flags %b addr %h data %h sum %h; b flags %b want all zero",
               {wren_a, busy_a, done_a, match_a, s_ready_a}, address_a, data_a, checksum_a,
               {wren_b, busy_b, done_b, s_ready_b});
    end
  endtask

  task automatic test_basic();
    stim = '{8'h11, 8'h22, 8'h33};
    run_load(0, 3, 1'b0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_wide();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1, 2, 1'b0, 1'b0, 1'b0, "wide");
  endtask

  task automatic test_wrap();
    stim = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    run_load(2, 4, 1'b1, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_corrupt();
    stim = '{8'h11, 8'h22, 8'h33};
    run_load(0, 3, 1'b0, 1'b1, 1'b0, "corrupt");
  endtask

  task automatic test_zero_length();
    wr_log.delete();
    sel = 0;
    @(negedge clock);
    length  = '0;
    s_valid = 1'b1;
    s_data  = 8'h77;
    set_start(0, 1'b1);
    @(negedge clock);
    set_start(0, 1'b0);
    #1;
    tests_run++;
    if (busy_a !== 1'b1 || done_a !== 1'b0 || s_ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_len cycle1: busy %b done %b ready %b want 1 0 0", busy_a, done_a, s_ready_a);
    end
    @(negedge clock);
    #1;
    tests_run++;
    if (done_a !== 1'b1 || match_a !== 1'b1 || busy_a !== 1'b0 || s_ready_a !== 1'b0 ||
        checksum_a !== 8'h00 || wr_log.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_len cycle2: done %b match %b busy %b ready %b sum %h writes %0d want 1 1 0 0 00 0",
               done_a, match_a, busy_a, s_ready_a, checksum_a, wr_log.size());
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    sel = 0;
    @(negedge clock);
    length = 5'd3;
    set_start(0, 1'b1);
    @(negedge clock);
    set_start(0, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'hC1;
    @(negedge clock);
    s_data  = 8'hC2;
    @(negedge clock);
    s_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (wren_a !== 1'b0 || busy_a !== 1'b0 || s_ready_a !== 1'b0 || checksum_a !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_abort: wren %b busy %b ready %b sum %h want 0 0 0 00",
               wren_a, busy_a, s_ready_a, checksum_a);
    end
    @(negedge clock);
    reset = 1'b0;
    stim = '{8'h5A};
    run_load(0, 1, 1'b0, 1'b0, 1'b0, "restart");
  endtask

  task automatic test_full_region();
    run_load(2, 17, 1'b1, 1'b0, 1'b0, "full_clamp");
    run_load(1, 16, 1'b0, 1'b0, 1'b0, "full_wide");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      run_load($urandom_range(0, 2), $urandom_range(1, 20), 1'($urandom_range(0, 1)),
               1'b0, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; mem_c[i] = '0;
    end
    reset = 1'b1;
    length = '0; s_valid = 1'b0; s_data = '0;
    set_start(0, 1'b0);
    sel = 0;
    #2;
    test_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    test_basic();
    test_wide();
    test_wrap();
    test_corrupt();
    test_zero_length();
    test_reset_abort();
    test_full_region();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
